// File: rtl/lcd_pattern_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pattern_sched_if
// Description : Coordinate, mode-request and pixel bundle between the LCD
//               driver side (master) and the pattern scheduler (slave).
// Revision    : 1.0  initial release
// ============================================================================
interface lcd_pattern_sched_if;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic        auto_en;
    logic [1:0]  mode_req;
    logic        mode_req_vld;
    logic        mode_req_ack;
    logic [1:0]  cur_mode;
    logic [15:0] frame_cnt;
    logic [15:0] pixel_data;

    modport master (
        output pixel_xpos, pixel_ypos, auto_en, mode_req, mode_req_vld,
        input  mode_req_ack, cur_mode, frame_cnt, pixel_data
    );

    modport slave (
        input  pixel_xpos, pixel_ypos, auto_en, mode_req, mode_req_vld,
        output mode_req_ack, cur_mode, frame_cnt, pixel_data
    );
endinterface
`default_nettype wire

// File: rtl/lcd_pattern_sched.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pattern_sched
// Description : RGB565 test-pattern scheduler/generator. Chooses one of four
//               patterns (bars, solid cycle, checker, grid) from a manual
//               request or an auto-rotate schedule; mode changes take effect
//               only on frame boundaries. Optional 1-px white border overlay
//               is enabled by defining PAT_BORDER_EN.
// Revision    : 1.0  initial release
// ============================================================================
`ifndef LCD_H_DISP
`define LCD_H_DISP 480
`endif
`ifndef LCD_V_DISP
`define LCD_V_DISP 272
`endif

module lcd_pattern_sched #(
    parameter int H_DISP       = `LCD_H_DISP,
    parameter int V_DISP       = `LCD_V_DISP,
    parameter int DWELL_FRAMES = 60,
    parameter int CELL_LOG2    = 5
) (
    input  wire logic          lcd_pclk,
    input  wire logic          rst_n,
    lcd_pattern_sched_if.slave bus
);

    localparam logic [15:0] c_white = 16'hFFFF;
    localparam logic [15:0] c_black = 16'h0000;
    localparam logic [15:0] c_red   = 16'hF800;
    localparam logic [15:0] c_green = 16'h07E0;
    localparam logic [15:0] c_blue  = 16'h001F;

    localparam logic [10:0] c_h_disp = 11'(H_DISP);
    localparam logic [10:0] c_v_disp = 11'(V_DISP);
    localparam logic [10:0] c_h_last = 11'(H_DISP - 1);
    localparam logic [10:0] c_v_last = 11'(V_DISP - 1);
    localparam logic [10:0] c_b1     = 11'(H_DISP / 5 * 1);
    localparam logic [10:0] c_b2     = 11'(H_DISP / 5 * 2);
    localparam logic [10:0] c_b3     = 11'(H_DISP / 5 * 3);
    localparam logic [10:0] c_b4     = 11'(H_DISP / 5 * 4);

    localparam int c_dwell_w = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [c_dwell_w-1:0] c_dwell_last = c_dwell_w'(DWELL_FRAMES - 1);

    typedef enum logic [0:0] {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } state_t;

    state_t               state_q,        state_d;
    logic [1:0]           cur_mode_q,     cur_mode_d;
    logic [15:0]          frame_cnt_q,    frame_cnt_d;
    logic [15:0]          pixel_data_q,   pixel_data_d;
    logic                 mode_req_ack_q, mode_req_ack_d;
    logic                 frame_end_q,    frame_end_d;
    logic                 pend_q,         pend_d;
    logic [1:0]           pend_mode_q,    pend_mode_d;
    logic [1:0]           solid_idx_q,    solid_idx_d;
    logic [c_dwell_w-1:0] dwell_q,        dwell_d;

    logic [10:0] w_x;
    logic [10:0] w_y;
    logic        w_active;
    logic [15:0] w_pat;
    logic        w_apply;

    assign w_x      = bus.pixel_xpos;
    assign w_y      = bus.pixel_ypos;
    assign w_active = (w_x < c_h_disp) && (w_y < c_v_disp);

    // Pattern pixel for the current coordinate under the mode held this cycle
    always_comb begin
        w_pat = c_black;
        case (cur_mode_q)
            2'd0: begin
                if      (w_x < c_b1) w_pat = c_white;
                else if (w_x < c_b2) w_pat = c_black;
                else if (w_x < c_b3) w_pat = c_red;
                else if (w_x < c_b4) w_pat = c_green;
                else                 w_pat = c_blue;
            end
            2'd1: begin
                case (solid_idx_q)
                    2'd0:    w_pat = c_red;
                    2'd1:    w_pat = c_green;
                    2'd2:    w_pat = c_blue;
                    default: w_pat = c_white;
                endcase
            end
            2'd2: w_pat = (w_x[CELL_LOG2] ^ w_y[CELL_LOG2]) ? c_white : c_black;
            default: begin
                w_pat = ((w_x[CELL_LOG2-1:0] == '0) || (w_y[CELL_LOG2-1:0] == '0))
                        ? c_white : c_black;
            end
        endcase
        if (!w_active) begin
            w_pat = c_black;
        end
`ifdef PAT_BORDER_EN
        if (w_active && ((w_x == '0) || (w_x == c_h_last) ||
                         (w_y == '0) || (w_y == c_v_last))) begin
            w_pat = c_white;
        end
`endif
    end

    // Next-state: frame-end detection, scheduling FSM and request capture
    always_comb begin
        state_d        = state_q;
        cur_mode_d     = cur_mode_q;
        frame_cnt_d    = frame_cnt_q;
        pend_d         = pend_q;
        pend_mode_d    = pend_mode_q;
        solid_idx_d    = solid_idx_q;
        dwell_d        = dwell_q;
        mode_req_ack_d = 1'b0;
        w_apply        = 1'b0;
        pixel_data_d   = w_pat;
        frame_end_d    = (w_x == c_h_last) && (w_y == c_v_last);

        if (frame_end_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            solid_idx_d = solid_idx_q + 2'd1;
            // A pending manual request is always honoured at the boundary
            if (pend_q) begin
                cur_mode_d = pend_mode_q;
                w_apply    = 1'b1;
            end
            case (state_q)
                ST_MANUAL: begin
                    if (bus.auto_en) begin
                        state_d = ST_AUTO;
                        dwell_d = '0;
                    end
                end
                default: begin
                    if (!bus.auto_en) begin
                        state_d = ST_MANUAL;
                    end else if (pend_q) begin
                        dwell_d = '0;
                    end else if (dwell_q == c_dwell_last) begin
                        cur_mode_d = cur_mode_q + 2'd1;
                        dwell_d    = '0;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            endcase
            mode_req_ack_d = w_apply;
        end

        if (w_apply) begin
            pend_d = 1'b0;
        end
        // A strobe in the frame-end cycle survives as pending for next frame
        if (bus.mode_req_vld) begin
            pend_d      = 1'b1;
            pend_mode_d = bus.mode_req;
        end
    end

    // State and registered outputs
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_MANUAL;
            cur_mode_q     <= 2'd0;
            frame_cnt_q    <= 16'd0;
            pixel_data_q   <= 16'd0;
            mode_req_ack_q <= 1'b0;
            frame_end_q    <= 1'b0;
            pend_q         <= 1'b0;
            pend_mode_q    <= 2'd0;
            solid_idx_q    <= 2'd0;
            dwell_q        <= '0;
        end else begin
            state_q        <= state_d;
            cur_mode_q     <= cur_mode_d;
            frame_cnt_q    <= frame_cnt_d;
            pixel_data_q   <= pixel_data_d;
            mode_req_ack_q <= mode_req_ack_d;
            frame_end_q    <= frame_end_d;
            pend_q         <= pend_d;
            pend_mode_q    <= pend_mode_d;
            solid_idx_q    <= solid_idx_d;
            dwell_q        <= dwell_d;
        end
    end

    assign bus.pixel_data   = pixel_data_q;
    assign bus.cur_mode     = cur_mode_q;
    assign bus.frame_cnt    = frame_cnt_q;
    assign bus.mode_req_ack = mode_req_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_pattern_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_pattern_sched
// Description : Self-checking bench for lcd_pattern_sched: directed boundary
//               cases plus randomized frames against a behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lcd_pattern_sched;

    localparam int H  = 64;
    localparam int V  = 48;
    localparam int DW = 2;
    localparam int CL = 5;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    lcd_pattern_sched_if bif ();

    lcd_pattern_sched #(
        .H_DISP      (H),
        .V_DISP      (V),
        .DWELL_FRAMES(DW),
        .CELL_LOG2   (CL)
    ) dut (
        .lcd_pclk(clk),
        .rst_n   (rst_n),
        .bus     (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: what the design should be showing after each edge
    int m_pix, m_mode, m_cnt, m_ack, m_pmode, m_dwell, m_idx;
    bit m_pend, m_auto, m_fe;

    int bars  [5] = '{32'hFFFF, 32'h0000, 32'hF800, 32'h07E0, 32'h001F};
    int solid [4] = '{32'hF800, 32'h07E0, 32'h001F, 32'hFFFF};
    int seq   [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_pix(int x, int y, int mode, int idx);
        int k;
        if (x >= H || y >= V) return 0;
        case (mode)
            0: begin
                k = x / (H / 5);
                if (k > 4) k = 4;
                return bars[k];
            end
            1:       return solid[idx];
            2:       return ((((x >> CL) + (y >> CL)) % 2) == 1) ? 32'hFFFF : 0;
            default: return ((x % (1 << CL)) == 0 || (y % (1 << CL)) == 0) ? 32'hFFFF : 0;
        endcase
    endfunction

    function automatic void model_reset();
        m_pix = 0; m_mode = 0; m_cnt = 0; m_ack = 0; m_pmode = 0;
        m_dwell = 0; m_idx = 0; m_pend = 0; m_auto = 0; m_fe = 0;
    endfunction

    // One pixel clock of the reference, from the rules on frame boundaries
    function automatic void model_clock(int x, int y, bit vld, int req, bit aen);
        int n_mode  = m_mode;
        int n_dwell = m_dwell;
        int n_idx   = m_idx;
        int n_cnt   = m_cnt;
        int n_pmode = m_pmode;
        bit n_pend  = m_pend;
        bit n_auto  = m_auto;
        int n_ack   = 0;
        m_pix = exp_pix(x, y, m_mode, m_idx);
        if (m_fe) begin
            n_cnt = (m_cnt + 1) % 65536;
            n_idx = (m_idx + 1) % 4;
            if (m_pend) begin
                n_mode  = m_pmode;
                n_ack   = 1;
                n_pend  = 0;
                n_dwell = 0;
            end else if (m_auto && aen) begin
                if (m_dwell == DW - 1) begin
                    n_mode  = (m_mode + 1) % 4;
                    n_dwell = 0;
                end else begin
                    n_dwell = m_dwell + 1;
                end
            end
            if (aen && !m_auto) n_dwell = 0;
            n_auto = aen;
        end
        if (vld) begin
            n_pend  = 1;
            n_pmode = req;
        end
        m_fe = (x == H - 1) && (y == V - 1);
        m_mode = n_mode; m_dwell = n_dwell; m_idx = n_idx; m_cnt = n_cnt;
        m_pmode = n_pmode; m_pend = n_pend; m_auto = n_auto; m_ack = n_ack;
    endfunction

    task automatic step(input int x, input int y, input bit vld, input int req);
        bif.pixel_xpos   = 11'(x);
        bif.pixel_ypos   = 11'(y);
        bif.mode_req_vld = vld;
        bif.mode_req     = 2'(req);
        model_clock(x, y, vld, req, bif.auto_en);
        @(posedge clk);
        #1;
        check_eq("pix",  32'(bif.pixel_data),   32'(m_pix));
        check_eq("mode", 32'(bif.cur_mode),     32'(m_mode));
        check_eq("ack",  32'(bif.mode_req_ack), 32'(m_ack));
        check_eq("cnt",  32'(bif.frame_cnt),    32'(m_cnt));
    endtask

    // Last active pixel, then one blanking cycle (the frame-end cycle)
    task automatic end_frame(input bit vld, input int req);
        step(H - 1, V - 1, 0, 0);
        step(H + 1, V + 1, vld, req);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_pix",  32'(bif.pixel_data),   0);
        check_eq("rst_mode", 32'(bif.cur_mode),     0);
        check_eq("rst_cnt",  32'(bif.frame_cnt),    0);
        check_eq("rst_ack",  32'(bif.mode_req_ack), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic random_frame(input bit toggle_auto);
        int n      = $urandom_range(4, 12);
        int strobe = $urandom_range(0, 2 * n);
        int flip   = $urandom_range(0, n - 1);
        for (int i = 0; i < n; i++) begin
            if (toggle_auto && i == flip) bif.auto_en = ~bif.auto_en;
            step($urandom_range(0, H + 3), $urandom_range(0, V + 3),
                 (i == strobe) || ($urandom_range(0, 9) == 0), $urandom_range(0, 3));
        end
        end_frame($urandom_range(0, 5) == 0, $urandom_range(0, 3));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        bif.pixel_xpos   = '0;
        bif.pixel_ypos   = '0;
        bif.auto_en      = 1'b0;
        bif.mode_req     = '0;
        bif.mode_req_vld = 1'b0;
        rst_n            = 1'b0;
        #2;
        apply_reset();

        // Colour bars at each boundary of the default mode
        step(0, 5, 0, 0);      check_eq("bar_white", 32'(bif.pixel_data), 32'hFFFF);
        step(H/5, 5, 0, 0);    check_eq("bar_black", 32'(bif.pixel_data), 32'h0000);
        step(2*H/5, 5, 0, 0);  check_eq("bar_red",   32'(bif.pixel_data), 32'hF800);
        step(3*H/5, 5, 0, 0);  check_eq("bar_green", 32'(bif.pixel_data), 32'h07E0);
        step(H - 1, 5, 0, 0);  check_eq("bar_blue",  32'(bif.pixel_data), 32'h001F);
        step(H + 2, 5, 0, 0);  check_eq("outside",   32'(bif.pixel_data), 32'h0000);

        // Mid-frame request held until the boundary
        step(20, 7, 1, 2);     check_eq("hold_mode", 32'(bif.cur_mode), 0);
        step(5, 5, 0, 0);
        end_frame(0, 0);
        check_eq("ack_fe",   32'(bif.mode_req_ack), 1);
        check_eq("mode_fe",  32'(bif.cur_mode),     2);
        step(32, 0, 0, 0);     check_eq("chk_32_0",  32'(bif.pixel_data), 32'hFFFF);
        check_eq("ack_once", 32'(bif.mode_req_ack), 0);
        step(32, 32, 0, 0);    check_eq("chk_32_32", 32'(bif.pixel_data), 32'h0000);
        end_frame(0, 0);

        // Two strobes in one frame: last wins, single acknowledge
        step(3, 3, 1, 1);
        step(4, 4, 1, 3);
        end_frame(0, 0);
        check_eq("last_wins", 32'(bif.cur_mode), 3);
        step(8, 8, 0, 0);      check_eq("single_ack", 32'(bif.mode_req_ack), 0);

        // Strobe coincident with frame end is deferred one frame
        end_frame(1, 1);
        check_eq("coinc_noack", 32'(bif.mode_req_ack), 0);
        check_eq("coinc_mode",  32'(bif.cur_mode),     3);
        step(2, 2, 0, 0);
        end_frame(0, 0);
        check_eq("coinc_ack",  32'(bif.mode_req_ack), 1);
        check_eq("coinc_next", 32'(bif.cur_mode),     1);

        // Solid colours over several frames
        for (int f = 0; f < 5; f++) begin
            step(10, 10, 0, 0);
            step(H - 2, V - 2, 0, 0);
            end_frame(0, 0);
        end

        // Auto rotation from a fresh reset
        apply_reset();
        bif.auto_en = 1'b1;
        for (int f = 0; f < 10; f++) begin
            step($urandom_range(0, H - 1), $urandom_range(0, V - 2), 0, 0);
            if (f > 0) check_eq("auto_seq", 32'(bif.cur_mode), 32'(seq[f - 1]));
            check_eq("frame_cnt", 32'(bif.frame_cnt), 32'(f));
            step($urandom_range(0, H - 1), $urandom_range(0, V - 2), 0, 0);
            end_frame(0, 0);
        end

        // Randomized frames, with mid-frame auto_en toggles and strobes
        for (int f = 0; f < 200; f++) begin
            random_frame($urandom_range(0, 3) == 0);
        end

        // Asynchronous reset in the middle of a frame
        step(7, 9, 1, 2);
        #3;
        apply_reset();
        step(0, 0, 0, 0);
        check_eq("post_rst_pix", 32'(bif.pixel_data), 32'hFFFF);
        for (int f = 0; f < 20; f++) begin
            random_frame(1'b1);
        end

        // Frame counter wrap from 0xFFFF
        force dut.frame_cnt_d = 16'hFFFF;
        m_cnt = 16'hFFFF;
        step(H + 1, 0, 0, 0);
        release dut.frame_cnt_d;
        step(1, 1, 0, 0);
        check_eq("cnt_preload", 32'(bif.frame_cnt), 32'hFFFF);
        end_frame(0, 0);
        check_eq("cnt_wrap", 32'(bif.frame_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
